input_scan_ctrl: RTL

Scan controller that time-shares one agreement filter across several raw digital inputs. A prescaler sets the sample rate. Each scan samples every channel once and shifts the sample into a per-channel history. A channel's filtered level changes only after STAGES consecutive samples agree. Each level change is reported to downstream logic as an event over a valid/ready handshake, with round-robin fairness between channels.

---
 rtl/input_scan_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/input_scan_ctrl.sv
// input_scan_ctrl: time-shared agreement filter over CHANNELS raw inputs.
// A prescaler fires a scan every DIV cycles; each scan shifts one synchronized
// sample per channel into its history and flips the filtered level once STAGES
// samples agree. Level changes are queued as pending bits and drained through
// a single valid/ready event register with round-robin arbitration.
// Optional feature macro: EVT_OVERRUN_EN adds the sticky o_ovr output.
module input_scan_ctrl #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV      = 1000,
    parameter int unsigned STAGES   = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [CHANNELS-1:0]         i_in,
    output logic [CHANNELS-1:0]         o_filt,
    output logic                        o_evt_valid,
    input  logic                        i_evt_ready,
    output logic [$clog2(CHANNELS)-1:0] o_evt_chan,
    output logic                        o_evt_level
`ifdef EVT_OVERRUN_EN
    ,
    output logic                        o_ovr
`endif
);

    localparam int unsigned CW   = $clog2(CHANNELS);
    localparam int unsigned CNTW = $clog2(DIV);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CNTW-1:0]     r_cnt;
    logic                w_tick;
    state_e              r_state;
    state_e              w_state_next;
    logic [CW-1:0]       r_k;
    logic [CW-1:0]       w_k_next;
    logic                w_scan;

    logic [STAGES-1:0]   r_hist [CHANNELS];
    logic [STAGES-1:0]   w_hist_new;
    logic                w_agree;
    logic                w_toggle;
    logic [CHANNELS-1:0] r_filt;
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] w_pend_set;
    logic [CHANNELS-1:0] w_pend_clr;
    logic [CHANNELS-1:0] w_cand;

    logic [CW-1:0]       r_rr;
    logic [CW:0]         w_try;
    logic                w_sel_found;
    logic [CW-1:0]       w_sel;
    logic                w_load;
    logic                r_evt_valid;
    logic [CW-1:0]       r_evt_chan;
    logic                r_evt_level;

    // Two-flop synchronizer; intentionally without reset.
    always_ff @(posedge i_clk) begin
        r_sync1 <= i_in;
        r_sync2 <= r_sync1;
    end

    assign w_tick = (r_cnt == CNTW'(DIV - 1));

    // Prescaler counting 0..DIV-1.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    // Scan FSM state and channel index registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
        end
    end

    // Scan FSM next state: walk channels 0..CHANNELS-1 once per tick.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_scan       = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_tick) begin
                    w_state_next = StScan;
                    w_k_next     = '0;
                end
            end
            StScan: begin
                w_scan = 1'b1;
                if (r_k == CW'(CHANNELS - 1)) begin
                    w_state_next = StIdle;
                    w_k_next     = '0;
                end else begin
                    w_k_next = r_k + CW'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
                w_k_next     = '0;
            end
        endcase
    end

    // Agreement check on the channel currently being scanned.
    always_comb begin
        w_hist_new = {r_hist[r_k][STAGES-2:0], r_sync2[r_k]};
        w_agree    = (w_hist_new == '0) || (w_hist_new == '1);
        w_toggle   = w_scan && w_agree && (w_hist_new[0] != r_filt[r_k]);
        w_pend_set = '0;
        if (w_toggle) begin
            w_pend_set[r_k] = 1'b1;
        end
    end

    // Round-robin pick of the first pending channel at or after r_rr.
    // A channel being set this cycle is excluded so the fresh set survives.
    always_comb begin
        w_cand      = r_pend & ~w_pend_set;
        w_sel_found = 1'b0;
        w_sel       = '0;
        w_try       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_try = {1'b0, r_rr} + (CW + 1)'(i);
            if (w_try >= (CW + 1)'(CHANNELS)) begin
                w_try = w_try - (CW + 1)'(CHANNELS);
            end
            if (!w_sel_found && w_cand[w_try[CW-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel       = w_try[CW-1:0];
            end
        end
    end

    assign w_load = !r_evt_valid || i_evt_ready;

    // One-hot clear of the channel taken by the event register.
    always_comb begin
        w_pend_clr = '0;
        if (w_load && w_sel_found) begin
            w_pend_clr[w_sel] = 1'b1;
        end
    end

    // History, filtered level and pending flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_hist[i] <= '0;
            end
            r_filt <= '0;
            r_pend <= '0;
        end else begin
            if (w_scan) begin
                r_hist[r_k] <= w_hist_new;
            end
            r_filt <= r_filt ^ w_pend_set;
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

    // Event output register; holds while presented and not accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_evt_level <= 1'b0;
            r_rr        <= '0;
        end else if (w_load) begin
            r_evt_valid <= w_sel_found;
            if (w_sel_found) begin
                r_evt_chan  <= w_sel;
                r_evt_level <= r_filt[w_sel];
                r_rr        <= (w_sel == CW'(CHANNELS - 1)) ? '0 : w_sel + CW'(1);
            end
        end
    end

`ifdef EVT_OVERRUN_EN
    logic r_ovr;

    // Sticky flag: a level change was folded into an entry not yet delivered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovr <= 1'b0;
        end else if (w_toggle && (r_pend[r_k] ||
                     (r_evt_valid && !i_evt_ready && r_evt_chan == r_k))) begin
            r_ovr <= 1'b1;
        end
    end

    assign o_ovr = r_ovr;
`endif

    assign o_filt      = r_filt;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_chan  = r_evt_chan;
    assign o_evt_level = r_evt_level;

endmodule
